hfrv_trace_capture: RTL and testbench
=====================================

// Module: hfrv_trace_capture
// PURPOSE
//  Synthesizable retired-instruction trace unit for HF-RISC, beside the core in dut_top.
//  Classifies every retired instruction into 8 opcode classes and keeps saturating per-class hit counters.
//  Captures class-filtered, trigger-qualified entries into a FIFO that a bench or host drains.
//  Unlike the software monitor, tracing is armable, triggerable, length-limited and has a selectable overflow policy.
// PARAMETERS
//  XLEN          32  data/PC width
//  DEPTH         16  FIFO entries; power of 2, >=2
//  CNT_W         32  width of class counters and drop counter
//  SEQ_W         16  width of entry sequence number, wraps
//  STOP_ON_FULL  1   1: drop new entry when full; 0: overwrite oldest
// PORTS
//  clk           in   1        clock, rising edge
//  reset         in   1        asynchronous, active-high
//  retire_valid  in   1        one instruction retired this cycle
//  retire_pc     in   XLEN     PC of retired instruction
//  retire_instr  in   32       instruction word
//  retire_rd     in   5        destination register
//  retire_wdata  in   XLEN     value written to rd
//  arm           in   1        pulse: flush FIFO, clear seq/overflow/drop_count, enter ARMED
//  abort         in   1        pulse: return to IDLE; FIFO contents kept
//  trig_en       in   1        1: wait for retire_pc==trig_pc; 0: trigger on first retire
//  trig_pc       in   XLEN     trigger address
//  capture_len   in   16       entries captured after trigger; 0 = unlimited
//  class_mask    in   8        per-class capture enable
//  out_valid     out  1        FIFO head valid
//  out_ready     in   1        consumer accepts head
//  out_data      out  2*XLEN+37+SEQ_W  {seq, pc, instr, rd, wdata}
//  level         out  $clog2(DEPTH)+1  FIFO occupancy
//  state_o       out  2        FSM state encoding
//  overflow      out  1        sticky: at least one entry dropped or overwritten
//  drop_count    out  CNT_W    saturating dropped/overwritten entries
//  cnt_sel       in   3        class counter select
//  cnt_value     out  CNT_W    selected counter, combinational read
//  cnt_clear     in   1        zero all class counters
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, out_valid=0, level=0, overflow=0, drop_count=0, seq=0, counters=0.
//  Classes from instr[6:0]: LOAD, STORE, OPIMM, OP, UPPER(LUI/AUIPC), BRANCH, JUMP(JAL/JALR), OTHER.
//  Class counters: +1 per retire_valid in any state; saturate at all-ones. cnt_clear beats a same-cycle increment.
//  FSM: IDLE -arm-> ARMED; ARMED -trigger-> CAPTURE; CAPTURE -captured==capture_len!=0-> DONE; DONE -arm-> ARMED.
//   abort from any state -> IDLE. Same-cycle arm+abort: abort wins. arm in ARMED/CAPTURE re-arms.
//   Trigger retire is itself a capture candidate in the same cycle.
//  Capture candidate: retire_valid && state in {ARMED-with-trigger, CAPTURE} && class_mask[class].
//   Each candidate increments the post-trigger count and seq, whether it is stored or dropped.
//  Push latency: candidate at edge N -> entry visible at head (out_valid=1) after edge N+1; FWFT head.
//  Pop: out_valid && out_ready. Push+pop in the same cycle while full: both occur, no drop.
//  Full, push without pop: STOP_ON_FULL=1 drops new entry; STOP_ON_FULL=0 discards oldest, stores new.
//   Both set overflow=1 and increment drop_count (saturating). level stays DEPTH.
//  arm flush: FIFO emptied the edge after arm; a same-cycle retire is not captured.
//  Pointers wrap modulo DEPTH; seq wraps modulo 2^SEQ_W.
// STRUCTURE
//  Package hfrv_trace_pkg: trace_class_e enum, classify() function, trace_entry_t struct, FSM state enum.
//  Sub-module hfrv_trace_fifo: DEPTH x entry, FWFT, overwrite option, level, flush.
//  Top: FSM, classifier, counters, drop logic.
// TESTING
//  Reset mid-CAPTURE with 3 entries queued -> next cycle level=0, out_valid=0, state IDLE, counters 0.
//  trig_en=1, trig_pc=0x100, capture_len=4, retires 0xF8..0x114 -> 4 entries, pcs 0x100..0x10C, seq 0..3, state DONE.
//  class_mask=8'h04, mix of ADDI/ADD/LW -> only ADDI captured; counter OPIMM = ADDI count, LOAD/OP count too.
//  DEPTH=4, STOP_ON_FULL=1, out_ready=0, 6 retires -> seq 0..3 kept, drop_count=2, overflow=1.
//  DEPTH=4, STOP_ON_FULL=0, same stimulus -> seq 2..5 kept, drop_count=2; full push+pop -> drop_count unchanged.
//  Counter preloaded to all-ones + retire -> holds; cnt_clear with retire -> 0; arm+abort same cycle -> IDLE.

Source files
------------

// File: rtl/hfrv_trace_pkg.sv
// Shared types for the HF-RISC retired-instruction trace unit: opcode classes,
// FSM states (IDLE idle, ARMED waiting for trigger, CAPTURE storing, DONE length reached).
package hfrv_trace_pkg;

  localparam int unsigned TR_XLEN  = 32;
  localparam int unsigned TR_SEQ_W = 16;

  typedef enum logic [2:0] {
    CL_LOAD   = 3'd0,
    CL_STORE  = 3'd1,
    CL_OPIMM  = 3'd2,
    CL_OP     = 3'd3,
    CL_UPPER  = 3'd4,
    CL_BRANCH = 3'd5,
    CL_JUMP   = 3'd6,
    CL_OTHER  = 3'd7
  } trace_class_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  // Packed layout of out_data for the default XLEN/SEQ_W configuration.
  typedef struct packed {
    logic [TR_SEQ_W-1:0] seq;
    logic [TR_XLEN-1:0]  pc;
    logic [31:0]         instr;
    logic [4:0]          rd;
    logic [TR_XLEN-1:0]  wdata;
  } trace_entry_t;

  function automatic trace_class_e classify(input logic [6:0] opcode);
    case (opcode)
      7'b0000011:           return CL_LOAD;
      7'b0100011:           return CL_STORE;
      7'b0010011:           return CL_OPIMM;
      7'b0110011:           return CL_OP;
      7'b0110111,
      7'b0010111:           return CL_UPPER;
      7'b1100011:           return CL_BRANCH;
      7'b1101111,
      7'b1100111:           return CL_JUMP;
      default:              return CL_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/hfrv_trace_fifo.sv
// First-word-fall-through trace FIFO with flush, occupancy and optional
// overwrite-oldest behaviour when pushed while full.
module hfrv_trace_fifo #(
  parameter int unsigned W         = 117,
  parameter int unsigned DEPTH     = 16,
  parameter bit          OVERWRITE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_ovw;
  logic w_rd_adv;

  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_pop    = pop && (r_count != '0);
  assign w_wr     = push && (!w_full || w_pop || OVERWRITE);
  // Overwrite lands on the oldest slot (wr_ptr == rd_ptr when full), so the read side skips it.
  assign w_ovw    = push && w_full && !w_pop && OVERWRITE;
  assign w_rd_adv = w_pop || w_ovw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_adv) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd_adv})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !flush) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign valid = (r_count != '0);
  assign full  = w_full;
  assign level = r_count;

endmodule

// File: rtl/hfrv_trace_capture.sv
// Retired-instruction trace unit: per-class hit counters, armable/triggerable
// capture FSM and a staged push into the trace FIFO with drop accounting.
module hfrv_trace_capture
  import hfrv_trace_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned SEQ_W        = 16,
  parameter bit          STOP_ON_FULL = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      retire_valid,
  input  logic [XLEN-1:0]           retire_pc,
  input  logic [31:0]               retire_instr,
  input  logic [4:0]                retire_rd,
  input  logic [XLEN-1:0]           retire_wdata,
  input  logic                      arm,
  input  logic                      abort,
  input  logic                      trig_en,
  input  logic [XLEN-1:0]           trig_pc,
  input  logic [15:0]               capture_len,
  input  logic [7:0]                class_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*XLEN+36+SEQ_W:0]  out_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic [1:0]                state_o,
  output logic                      overflow,
  output logic [CNT_W-1:0]          drop_count,
  input  logic [2:0]                cnt_sel,
  output logic [CNT_W-1:0]          cnt_value,
  input  logic                      cnt_clear
);

  localparam int unsigned EW = 2*XLEN + 37 + SEQ_W;

  trace_state_e      r_state;
  trace_state_e      w_state_nxt;
  trace_class_e      w_class;
  logic [15:0]       r_cap_cnt;
  logic [15:0]       w_cap_nxt;
  logic [SEQ_W-1:0]  r_seq;
  logic              r_pend_valid;
  logic [EW-1:0]     r_pend_data;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [CNT_W-1:0]  r_cnt [8];

  logic w_arm;
  logic w_trig;
  logic w_cand;
  logic w_len_hit;
  logic w_drop;
  logic w_fifo_full;

  assign w_class   = classify(retire_instr[6:0]);
  assign w_arm     = arm && !abort;
  assign w_trig    = retire_valid && (!trig_en || (retire_pc == trig_pc));
  // arm/abort cycles never capture: arm flushes, abort leaves the capture window.
  assign w_cand    = retire_valid && !arm && !abort && class_mask[w_class] &&
                     (((r_state == ST_ARMED) && w_trig) || (r_state == ST_CAPTURE));
  assign w_cap_nxt = r_cap_cnt + {15'd0, w_cand};
  assign w_len_hit = (capture_len != 16'd0) && (w_cap_nxt == capture_len);
  assign w_drop    = r_pend_valid && w_fifo_full && !out_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else if (arm) begin
      w_state_nxt = ST_ARMED;
    end else begin
      case (r_state)
        ST_ARMED:   if (w_trig) w_state_nxt = w_len_hit ? ST_DONE : ST_CAPTURE;
        ST_CAPTURE: if (w_len_hit) w_state_nxt = ST_DONE;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cap_cnt    <= '0;
      r_seq        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_overflow   <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_arm) begin
        r_cap_cnt    <= '0;
        r_seq        <= '0;
        r_pend_valid <= 1'b0;
        r_overflow   <= 1'b0;
        r_drop_cnt   <= '0;
      end else begin
        r_pend_valid <= w_cand;
        if (w_cand) begin
          r_cap_cnt   <= w_cap_nxt;
          r_seq       <= r_seq + 1'b1;
          r_pend_data <= {r_seq, retire_pc, retire_instr, retire_rd, retire_wdata};
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
          if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
    end else if (cnt_clear) begin
      for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
    end else if (retire_valid && (r_cnt[w_class] != '1)) begin
      r_cnt[w_class] <= r_cnt[w_class] + 1'b1;
    end
  end

  hfrv_trace_fifo #(
    .W         (EW),
    .DEPTH     (DEPTH),
    .OVERWRITE (!STOP_ON_FULL)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .flush (w_arm),
    .push  (r_pend_valid),
    .pop   (out_ready),
    .wdata (r_pend_data),
    .rdata (out_data),
    .valid (out_valid),
    .full  (w_fifo_full),
    .level (level)
  );

  assign state_o    = r_state;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_cnt;
  assign cnt_value  = r_cnt[cnt_sel];

endmodule

// File: tb/tb_hfrv_trace_capture.sv
// Directed scoreboard bench: one drop-on-full and one overwrite-oldest instance,
// both DEPTH=4 with 4-bit counters so saturation is reachable.
module tb_hfrv_trace_capture;
  import hfrv_trace_pkg::*;

  localparam int EW = 117;
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] ADD  = 32'h001080B3;
  localparam logic [31:0] LW   = 32'h00002103;

  logic        clk = 1'b0;
  logic        reset;
  logic        retire_valid;
  logic [31:0] retire_pc, retire_instr, retire_wdata, trig_pc;
  logic [4:0]  retire_rd;
  logic        arm, abort, trig_en, cnt_clear, out_ready, ow_ready;
  logic [15:0] capture_len;
  logic [7:0]  class_mask;
  logic [2:0]  cnt_sel;

  logic          out_valid, overflow, ow_valid, ow_overflow;
  logic [EW-1:0] out_data, ow_data;
  logic [2:0]    level, ow_level;
  logic [1:0]    state_o, ow_state;
  logic [3:0]    drop_count, cnt_value, ow_drop, ow_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  logic [EW-1:0] q_main[$];
  logic [EW-1:0] q_ow[$];
  int exp_cnt[8];

  always #10 clk = ~clk;

  hfrv_trace_capture #(.XLEN(32), .DEPTH(4), .CNT_W(4), .SEQ_W(16), .STOP_ON_FULL(1'b1)) u_dut (
    .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_instr(retire_instr), .retire_rd(retire_rd), .retire_wdata(retire_wdata),
    .arm(arm), .abort(abort), .trig_en(trig_en), .trig_pc(trig_pc), .capture_len(capture_len),
    .class_mask(class_mask), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .state_o(state_o), .overflow(overflow), .drop_count(drop_count),
    .cnt_sel(cnt_sel), .cnt_value(cnt_value), .cnt_clear(cnt_clear));

  hfrv_trace_capture #(.XLEN(32), .DEPTH(4), .CNT_W(4), .SEQ_W(16), .STOP_ON_FULL(1'b0)) u_dut_ow (
    .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_instr(retire_instr), .retire_rd(retire_rd), .retire_wdata(retire_wdata),
    .arm(arm), .abort(abort), .trig_en(trig_en), .trig_pc(trig_pc), .capture_len(capture_len),
    .class_mask(class_mask), .out_valid(ow_valid), .out_ready(ow_ready), .out_data(ow_data),
    .level(ow_level), .state_o(ow_state), .overflow(ow_overflow), .drop_count(ow_drop),
    .cnt_sel(cnt_sel), .cnt_value(ow_cnt), .cnt_clear(cnt_clear));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int tb_class(input logic [31:0] ins);
    case (ins[6:0])
      7'h03:        return 0;
      7'h23:        return 1;
      7'h13:        return 2;
      7'h33:        return 3;
      7'h37, 7'h17: return 4;
      7'h63:        return 5;
      7'h6F, 7'h67: return 6;
      default:      return 7;
    endcase
  endfunction

  function automatic logic [EW-1:0] mk(input int seq, input logic [31:0] pc, input logic [31:0] ins);
    trace_entry_t e;
    e.seq   = 16'(seq);
    e.pc    = pc;
    e.instr = ins;
    e.rd    = pc[6:2];
    e.wdata = ~pc;
    return e;
  endfunction

  task automatic clr_model();
    for (int i = 0; i < 8; i++) exp_cnt[i] = 0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] ins);
    int c;
    retire_valid = 1'b1;
    retire_pc    = pc;
    retire_instr = ins;
    retire_rd    = pc[6:2];
    retire_wdata = ~pc;
    if (cnt_clear) clr_model();
    else begin
      c = tb_class(ins);
      if (exp_cnt[c] < 15) exp_cnt[c]++;
    end
    tick();
    retire_valid = 1'b0;
  endtask

  task automatic chk_cnts(input string tag);
    for (int s = 0; s < 8; s++) begin
      cnt_sel = 3'(s);
      #1;
      chk($sformatf("%s_cnt%0d", tag, s), cnt_value, exp_cnt[s]);
    end
  endtask

  task automatic drain(input bit ow, input string tag);
    int budget = 50;
    logic v;
    logic [EW-1:0] d, e;
    int qs;
    if (ow) ow_ready = 1'b1; else out_ready = 1'b1;
    while (budget > 0) begin
      v  = ow ? ow_valid : out_valid;
      d  = ow ? ow_data : out_data;
      qs = ow ? q_ow.size() : q_main.size();
      if (!v && qs == 0) break;
      if (v) begin
        if (qs == 0) chk({tag, "_extra"}, v, 1'b0);
        else begin
          if (ow) e = q_ow.pop_front(); else e = q_main.pop_front();
          chk(tag, d, e);
        end
      end
      tick();
      budget--;
    end
    qs = ow ? q_ow.size() : q_main.size();
    chk({tag, "_left"}, qs, 0);
    if (ow) ow_ready = 1'b0; else out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [EW-1:0] e;
    int s;
    logic [31:0] prog [7];
    prog = '{ADDI, ADD, LW, ADDI, LW, ADD, ADDI};

    reset = 1'b1; retire_valid = 1'b0; retire_pc = '0; retire_instr = '0; retire_rd = '0;
    retire_wdata = '0; arm = 1'b0; abort = 1'b0; trig_en = 1'b0; trig_pc = '0; capture_len = '0;
    class_mask = 8'hFF; cnt_sel = '0; cnt_clear = 1'b0; out_ready = 1'b0; ow_ready = 1'b1;
    clr_model();
    repeat (2) tick();
    reset = 1'b0;
    tick();

    chk("rst_state", state_o, 2'd0);
    chk("rst_level", level, 3'd0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_drop", drop_count, 4'd0);
    chk_cnts("rst");

    // Trigger at 0x100, length 4
    trig_en = 1'b1; trig_pc = 32'h100; capture_len = 16'd4;
    arm = 1'b1; tick(); arm = 1'b0;
    chk("armed", state_o, 2'd1);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] pc;
      pc = 32'hF8 + 32'(4*i);
      if (pc >= 32'h100 && pc <= 32'h10C) q_main.push_back(mk(int'((pc - 32'h100) >> 2), pc, ADDI));
      retire(pc, ADDI);
    end
    tick();
    chk("trig_state", state_o, 2'd3);
    chk("trig_level", level, 3'd4);
    chk("trig_drop", drop_count, 4'd0);
    drain(1'b0, "trig");

    // Class filter: only OPIMM captured
    trig_en = 1'b0; capture_len = 16'd0; class_mask = 8'h04;
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0; clr_model();
    arm = 1'b1; tick(); arm = 1'b0;
    s = 0;
    for (int i = 0; i < 7; i++) begin
      if (tb_class(prog[i]) == 2) begin
        q_main.push_back(mk(s, 32'h300 + 32'(4*i), prog[i]));
        s++;
      end
      retire(32'h300 + 32'(4*i), prog[i]);
      if (i == 0) chk("lat_edge_n", out_valid, 1'b0);
      if (i == 1) chk("lat_edge_n1", out_valid, 1'b1);
    end
    tick();
    chk("mask_state", state_o, 2'd2);
    chk("mask_level", level, 3'd3);
    chk_cnts("mask");
    drain(1'b0, "mask");

    // Full FIFO: drop-new vs overwrite-oldest
    class_mask = 8'hFF; ow_ready = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4)  q_main.push_back(mk(i, 32'h400 + 32'(4*i), LW));
      if (i >= 2) q_ow.push_back(mk(i, 32'h400 + 32'(4*i), LW));
      retire(32'h400 + 32'(4*i), LW);
    end
    tick();
    chk("stop_level", level, 3'd4);
    chk("stop_drop", drop_count, 4'd2);
    chk("stop_ovf", overflow, 1'b1);
    chk("ow_level", ow_level, 3'd4);
    chk("ow_drop", ow_drop, 4'd2);
    chk("ow_ovf", ow_overflow, 1'b1);
    q_ow.push_back(mk(6, 32'h418, LW));
    retire(32'h418, LW);
    ow_ready = 1'b1;
    e = q_ow.pop_front();
    chk("ow_pushpop_head", ow_data, e);
    tick();
    ow_ready = 1'b0;
    chk("ow_pushpop_drop", ow_drop, 4'd2);
    chk("ow_pushpop_level", ow_level, 3'd4);
    chk("stop_drop3", drop_count, 4'd3);
    drain(1'b0, "stop");
    drain(1'b1, "ovw");

    // Counter saturation and clear priority
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_idle", state_o, 2'd0);
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0; clr_model();
    repeat (16) retire(32'h600, ADDI);
    cnt_sel = 3'd2; #1;
    chk("sat_hold", cnt_value, 4'hF);
    chk_cnts("sat");
    cnt_clear = 1'b1; retire(32'h604, ADDI); cnt_clear = 1'b0;
    chk_cnts("clr");

    // arm flush with a same-cycle retire, seq restart
    arm = 1'b1; tick(); arm = 1'b0;
    chk("arm_clr_ovf", overflow, 1'b0);
    chk("arm_clr_drop", drop_count, 4'd0);
    retire(32'h500, ADDI);
    retire(32'h504, ADDI);
    tick();
    chk("pre_flush_level", level, 3'd2);
    arm = 1'b1; retire(32'h508, ADDI); arm = 1'b0;
    chk("flush_level", level, 3'd0);
    tick();
    chk("flush_nocap", level, 3'd0);
    chk("flush_state", state_o, 2'd1);
    q_main.push_back(mk(0, 32'h50C, ADDI));
    retire(32'h50C, ADDI);
    drain(1'b0, "reseq");

    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    chk("arm_abort", state_o, 2'd0);

    // Reset in the middle of a capture
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 3; i++) retire(32'h700 + 32'(4*i), ADD);
    tick();
    chk("pre_rst_level", level, 3'd3);
    chk("pre_rst_state", state_o, 2'd2);
    #2 reset = 1'b1;
    tick();
    clr_model();
    q_main.delete();
    chk("mid_rst_level", level, 3'd0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_state", state_o, 2'd0);
    chk_cnts("mid_rst");
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
